// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states, grant encodings and counter width.
// The state encoding equals the grant code so grant can be driven straight from the state register.
package sram_arb_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] GRANT_IDLE = 2'd0;
    localparam logic [1:0] GRANT_CPU  = 2'd1;
    localparam logic [1:0] GRANT_DL   = 2'd2;
    localparam logic [1:0] GRANT_TAPE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = GRANT_IDLE,
        S_CPU  = GRANT_CPU,
        S_DL   = GRANT_DL,
        S_TAPE = GRANT_TAPE
    } state_e;

endpackage

// File: rtl/sram_arb_if.sv
// Bus bundle between the CPU, loader and tape clients and the arbiter's SDRAM port.
// The arbiter uses the slave modport; clients (or a bench) drive through master.
interface sram_arb_if #(
    parameter int ADDR_W = 25
);

    logic              cpu_rd;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic              cpu_rfsh_n;

    logic              dl_req;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_din;

    logic              tape_rd;
    logic [ADDR_W-1:0] tape_addr;
    logic [7:0]        tape_dout;
    logic              tape_valid;

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we;
    logic              mem_rd;
    logic [7:0]        mem_dout;

    logic [1:0]        grant;

    modport slave (
        input  cpu_rd, cpu_we, cpu_addr, cpu_din, cpu_rfsh_n,
        input  dl_req, dl_wr, dl_addr, dl_din,
        input  tape_rd, tape_addr,
        input  mem_dout,
        output tape_dout, tape_valid,
        output mem_addr, mem_din, mem_we, mem_rd,
        output grant
    );

    modport master (
        output cpu_rd, cpu_we, cpu_addr, cpu_din, cpu_rfsh_n,
        output dl_req, dl_wr, dl_addr, dl_din,
        output tape_rd, tape_addr,
        output mem_dout,
        input  tape_dout, tape_valid,
        input  mem_addr, mem_din, mem_we, mem_rd,
        input  grant
    );

endinterface

// File: rtl/sram_arb_tapefetch.sv
// Tape fetch engine: refresh-slot detection, one-byte address cache, fetch counter and data capture.
// Only instantiated when SRAM_ARB_TAPE_EN is defined.
module sram_arb_tapefetch
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = 25,
    parameter int ACK_DELAY = 7
) (
    input  logic              clk_sys,
    input  logic              nRESET,
    input  logic              i_in_cpu,
    input  logic              i_in_tape,
    input  logic              i_dl_req,
    input  logic              i_cpu_rfsh_n,
    input  logic              i_tape_rd,
    input  logic [ADDR_W-1:0] i_tape_addr,
    input  logic [7:0]        i_mem_dout,
    output logic              o_start,
    output logic              o_done,
    output logic              o_abort,
    output logic [ADDR_W-1:0] o_last_addr,
    output logic [7:0]        o_tape_dout,
    output logic              o_tape_valid
);

    logic              r_rfsh_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_cache_ok;
    logic [7:0]        r_tape_dout;
    logic              r_tape_valid;

    logic              w_slot;
    logic              w_hit;
    logic [CNT_W-1:0]  w_cnt_dec;

    // The start cycle counts toward the fetch length, so the fetch finishes when the
    // decremented count reaches 1, giving ACK_DELAY-1 cycles of SDRAM read in S_TAPE.
    always_comb begin
        w_slot      = i_in_cpu && !i_dl_req && r_rfsh_q && !i_cpu_rfsh_n && i_tape_rd;
        w_hit       = w_slot && r_cache_ok && (i_tape_addr == r_last_addr);
        o_start     = w_slot && !w_hit;
        w_cnt_dec   = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
        o_abort     = i_in_tape && i_cpu_rfsh_n;
        o_done      = i_in_tape && !i_dl_req && !i_cpu_rfsh_n && (w_cnt_dec == CNT_W'(1));
        o_last_addr = r_last_addr;
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            r_rfsh_q     <= 1'b1;
            r_cnt        <= '0;
            r_last_addr  <= '0;
            r_cache_ok   <= 1'b0;
            r_tape_dout  <= '0;
            r_tape_valid <= 1'b0;
        end else begin
            r_rfsh_q     <= i_cpu_rfsh_n;
            r_tape_valid <= 1'b0;
            if (o_start) begin
                r_last_addr <= i_tape_addr;
                r_cache_ok  <= 1'b0;
                r_cnt       <= CNT_W'(ACK_DELAY);
            end else if (i_in_tape) begin
                if (i_dl_req || o_abort) begin
                    r_cnt <= '0;
                end else if (o_done) begin
                    r_cnt        <= w_cnt_dec;
                    r_tape_dout  <= i_mem_dout;
                    r_tape_valid <= 1'b1;
                    r_cache_ok   <= 1'b1;
                end else begin
                    r_cnt <= w_cnt_dec;
                end
            end else if (w_hit) begin
                r_tape_valid <= 1'b1;
            end
        end
    end

    assign o_tape_dout  = r_tape_dout;
    assign o_tape_valid = r_tape_valid;

endmodule

// File: rtl/sram_arbiter.sv
// SDRAM port arbiter for CPU, loader and tape player (priority loader > tape slot > CPU).
// Define SRAM_ARB_TAPE_EN to build the tape fetch path; without it refresh slots are idle.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = 25,
    parameter int ACK_DELAY = 7
) (
    input  logic     clk_sys,
    input  logic     nRESET,
    sram_arb_if.slave bus
);

    state_e r_state;
    state_e w_state_next;

`ifdef SRAM_ARB_TAPE_EN
    logic              w_in_cpu;
    logic              w_in_tape;
    logic              w_start;
    logic              w_done;
    logic              w_abort;
    logic [ADDR_W-1:0] w_last_addr;

    assign w_in_cpu  = (r_state == S_CPU);
    assign w_in_tape = (r_state == S_TAPE);

    sram_arb_tapefetch #(
        .ADDR_W    (ADDR_W),
        .ACK_DELAY (ACK_DELAY)
    ) u_tapefetch (
        .clk_sys      (clk_sys),
        .nRESET       (nRESET),
        .i_in_cpu     (w_in_cpu),
        .i_in_tape    (w_in_tape),
        .i_dl_req     (bus.dl_req),
        .i_cpu_rfsh_n (bus.cpu_rfsh_n),
        .i_tape_rd    (bus.tape_rd),
        .i_tape_addr  (bus.tape_addr),
        .i_mem_dout   (bus.mem_dout),
        .o_start      (w_start),
        .o_done       (w_done),
        .o_abort      (w_abort),
        .o_last_addr  (w_last_addr),
        .o_tape_dout  (bus.tape_dout),
        .o_tape_valid (bus.tape_valid)
    );
`else
    logic w_unused_tape;

    assign bus.tape_dout  = '0;
    assign bus.tape_valid = 1'b0;
    assign w_unused_tape  = ^{bus.tape_rd, bus.tape_addr, bus.mem_dout, CNT_W'(ACK_DELAY)};
`endif

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The loader preempts everything, including an in-flight tape fetch.
    always_comb begin
        w_state_next = r_state;
        if (bus.dl_req) begin
            w_state_next = S_DL;
        end else begin
            case (r_state)
                S_IDLE: w_state_next = S_CPU;
                S_CPU: begin
`ifdef SRAM_ARB_TAPE_EN
                    if (w_start) begin
                        w_state_next = S_TAPE;
                    end
`endif
                end
                S_DL:   w_state_next = S_IDLE;
`ifdef SRAM_ARB_TAPE_EN
                S_TAPE: begin
                    if (w_done || w_abort) begin
                        w_state_next = S_CPU;
                    end
                end
`endif
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // CPU refresh cycles keep the address but never read or write.
    always_comb begin
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        bus.mem_we   = 1'b0;
        bus.mem_rd   = 1'b0;
        case (r_state)
            S_CPU: begin
                bus.mem_addr = bus.cpu_addr;
                if (bus.cpu_rfsh_n) begin
                    bus.mem_din = bus.cpu_din;
                    bus.mem_we  = bus.cpu_we;
                    bus.mem_rd  = bus.cpu_rd;
                end
            end
            S_DL: begin
                bus.mem_addr = bus.dl_addr;
                bus.mem_din  = bus.dl_din;
                bus.mem_we   = bus.dl_wr;
            end
`ifdef SRAM_ARB_TAPE_EN
            S_TAPE: begin
                bus.mem_addr = w_last_addr;
                bus.mem_rd   = !w_abort;
            end
`endif
            default: ;
        endcase
    end

    assign bus.grant = r_state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations. Covers both SRAM_ARB_TAPE_EN builds.
module tb_sram_arbiter;

   localparam int ADDR_W    = 25;
   localparam int ACK_DELAY = 7;
`ifdef SRAM_ARB_TAPE_EN
   localparam bit TAPE_EN = 1'b1;
`else
   localparam bit TAPE_EN = 1'b0;
`endif

   logic clk_sys = 1'b0;
   logic nRESET  = 1'b0;
   logic [7:0] rdData = 8'h00;

   // free-running 10-unit clock
   always #5 clk_sys = ~clk_sys;

   sram_arb_if #(.ADDR_W(ADDR_W)) bus ();

   // The SDRAM returns rdData only while it is being read, so a late capture is visible.
   assign bus.mem_dout = bus.mem_rd ? rdData : 8'hEE;

   sram_arbiter #(
      .ADDR_W    (ADDR_W),
      .ACK_DELAY (ACK_DELAY)
   ) dut (
      .clk_sys (clk_sys),
      .nRESET  (nRESET),
      .bus     (bus)
   );

   int testsRun    = 0;
   int testsFailed = 0;
   bit checkEn     = 1'b0;

   int                mOwner     = 0;
   int                mFetchLeft = 0;
   logic [ADDR_W-1:0] mLastAddr  = '0;
   bit                mCacheOk   = 1'b0;
   logic [7:0]        mTapeDout  = 8'h00;
   bit                mTapeValid = 1'b0;
   bit                mPrevRfsh  = 1'b1;
   bit                mFall;
   bit                mNewValid;

   int                rrRd, rrWe, rrValid, rrValidAt, rrGrant;
   logic [7:0]        rrDout;

   // Reference model: owner 0 idle, 1 CPU, 2 loader, 3 tape; a fetch reads for ACK_DELAY-1
   // cycles after the start cycle and is lost if refresh ends or the loader takes the bus.
   always @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         mOwner     = 0;
         mFetchLeft = 0;
         mLastAddr  = '0;
         mCacheOk   = 1'b0;
         mTapeDout  = 8'h00;
         mTapeValid = 1'b0;
         mPrevRfsh  = 1'b1;
      end else begin
         mFall     = mPrevRfsh && !bus.cpu_rfsh_n;
         mPrevRfsh = bus.cpu_rfsh_n;
         mNewValid = 1'b0;
         if (bus.dl_req) begin
            mOwner     = 2;
            mFetchLeft = 0;
         end else if (mOwner == 0) begin
            mOwner = 1;
         end else if (mOwner == 2) begin
            mOwner = 0;
         end else if (mOwner == 1) begin
            if (TAPE_EN && mFall && bus.tape_rd) begin
               if (mCacheOk && bus.tape_addr == mLastAddr) begin
                  mNewValid = 1'b1;
               end else begin
                  mLastAddr  = bus.tape_addr;
                  mCacheOk   = 1'b0;
                  mFetchLeft = ACK_DELAY - 1;
                  mOwner     = 3;
               end
            end
         end else begin
            if (bus.cpu_rfsh_n) begin
               mOwner     = 1;
               mFetchLeft = 0;
            end else begin
               mFetchLeft = mFetchLeft - 1;
               if (mFetchLeft == 0) begin
                  mTapeDout = rdData;
                  mNewValid = 1'b1;
                  mCacheOk  = 1'b1;
                  mOwner    = 1;
               end
            end
         end
         mTapeValid = mNewValid;
      end
   end

   // one comparison: counts it and reports a mismatch
   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // compares every DUT output against the model for the current cycle
   task automatic checkOutput();
      logic [ADDR_W-1:0] eAddr;
      logic [7:0]        eDin;
      logic              eRd;
      logic              eWe;
      eAddr = '0;
      eDin  = 8'h00;
      eRd   = 1'b0;
      eWe   = 1'b0;
      if (mOwner == 1) begin
         eAddr = bus.cpu_addr;
         if (bus.cpu_rfsh_n) begin
            eDin = bus.cpu_din;
            eRd  = bus.cpu_rd;
            eWe  = bus.cpu_we;
         end
      end else if (mOwner == 2) begin
         eAddr = bus.dl_addr;
         eDin  = bus.dl_din;
         eWe   = bus.dl_wr;
      end else if (mOwner == 3) begin
         eAddr = mLastAddr;
         eRd   = !bus.cpu_rfsh_n;
      end
      checkValue("grant", 64'(bus.grant), 64'(mOwner));
      checkValue("mem_addr", 64'(bus.mem_addr), 64'(eAddr));
      checkValue("mem_din", 64'(bus.mem_din), 64'(eDin));
      checkValue("mem_rd", 64'(bus.mem_rd), 64'(eRd));
      checkValue("mem_we", 64'(bus.mem_we), 64'(eWe));
      checkValue("tape_valid", 64'(bus.tape_valid), 64'(mTapeValid));
      checkValue("tape_dout", 64'(bus.tape_dout), 64'(mTapeDout));
   endtask

   always @(negedge clk_sys) begin
      if (checkEn) checkOutput();
   end

   task automatic nextCycle();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic applyStimulus(input logic rd, input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [7:0] din, input logic rfshN);
      nextCycle();
      bus.cpu_rd     = rd;
      bus.cpu_we     = we;
      bus.cpu_addr   = addr;
      bus.cpu_din    = din;
      bus.cpu_rfsh_n = rfshN;
   endtask

   // refresh low for lowCycles then high; optional tape_rd drop and two-cycle loader burst
   task automatic runRefresh(input int lowCycles, input int highCycles, input int dropAt, input int dlAt);
      rrRd      = 0;
      rrWe      = 0;
      rrValid   = 0;
      rrValidAt = -1;
      rrGrant   = -1;
      rrDout    = 8'h00;
      for (int c = 0; c < lowCycles + highCycles; c++) begin
         nextCycle();
         bus.cpu_rfsh_n = (c >= lowCycles);
         if (c == dropAt) bus.tape_rd = 1'b0;
         if (c == dlAt) bus.dl_req = 1'b1;
         if (c == dlAt + 2) bus.dl_req = 1'b0;
         @(negedge clk_sys);
         if (!bus.cpu_rfsh_n && bus.mem_rd) rrRd++;
         if (!bus.cpu_rfsh_n && bus.mem_we) rrWe++;
         if (bus.tape_valid) begin
            rrValid++;
            rrValidAt = c;
            rrDout    = bus.tape_dout;
            rrGrant   = int'(bus.grant);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.cpu_rd     = 1'b1;
      bus.cpu_we     = 1'b0;
      bus.cpu_addr   = 25'h0004000;
      bus.cpu_din    = 8'h00;
      bus.cpu_rfsh_n = 1'b1;
      bus.dl_req     = 1'b0;
      bus.dl_wr      = 1'b0;
      bus.dl_addr    = '0;
      bus.dl_din     = 8'h00;
      bus.tape_rd    = 1'b0;
      bus.tape_addr  = '0;
      nRESET         = 1'b0;

      nextCycle();
      checkEn = 1'b1;
      @(negedge clk_sys);
      checkValue("reset_grant", 64'(bus.grant), 64'd0);
      checkValue("reset_mem_rd", 64'(bus.mem_rd), 64'd0);
      checkValue("reset_tape_valid", 64'(bus.tape_valid), 64'd0);

      nextCycle();
      nRESET = 1'b1;
      @(negedge clk_sys);
      checkValue("release_grant_idle", 64'(bus.grant), 64'd0);
      nextCycle();
      @(negedge clk_sys);
      checkValue("release_grant_cpu", 64'(bus.grant), 64'd1);
      checkValue("release_mem_rd", 64'(bus.mem_rd), 64'd1);
      checkValue("release_mem_addr", 64'(bus.mem_addr), 64'h0004000);

      applyStimulus(1'b1, 1'b1, 25'h0002000, 8'h11, 1'b1);
      nextCycle();
      bus.dl_req  = 1'b1;
      bus.dl_wr   = 1'b1;
      bus.dl_addr = 25'h0180000;
      bus.dl_din  = 8'hA5;
      @(negedge clk_sys);
      checkValue("dl_req_cycle_grant", 64'(bus.grant), 64'd1);
      checkValue("dl_req_cycle_din", 64'(bus.mem_din), 64'h11);
      nextCycle();
      @(negedge clk_sys);
      checkValue("dl_grant", 64'(bus.grant), 64'd2);
      checkValue("dl_mem_we", 64'(bus.mem_we), 64'd1);
      checkValue("dl_mem_din", 64'(bus.mem_din), 64'hA5);
      checkValue("dl_mem_addr", 64'(bus.mem_addr), 64'h0180000);
      checkValue("dl_mem_rd", 64'(bus.mem_rd), 64'd0);
      nextCycle();
      bus.dl_addr = 25'h0180001;
      bus.dl_din  = 8'h5A;
      nextCycle();
      bus.dl_req = 1'b0;
      bus.dl_wr  = 1'b0;
      @(negedge clk_sys);
      checkValue("dl_fall_cycle_grant", 64'(bus.grant), 64'd2);
      nextCycle();
      @(negedge clk_sys);
      checkValue("dl_after_grant_idle", 64'(bus.grant), 64'd0);
      nextCycle();
      @(negedge clk_sys);
      checkValue("dl_after_grant_cpu", 64'(bus.grant), 64'd1);

      applyStimulus(1'b1, 1'b1, 25'h0000100, 8'h77, 1'b1);
      nextCycle();
      bus.tape_rd   = 1'b1;
      bus.tape_addr = 25'h0400010;
      rdData        = 8'h3C;

`ifdef SRAM_ARB_TAPE_EN
      runRefresh(10, 2, -1, -1);
      checkValue("fetch_rd_cycles", 64'(rrRd), 64'd6);
      checkValue("fetch_we_cycles", 64'(rrWe), 64'd0);
      checkValue("fetch_valid_count", 64'(rrValid), 64'd1);
      checkValue("fetch_valid_at", 64'(rrValidAt), 64'd7);
      checkValue("fetch_dout", 64'(rrDout), 64'h3C);
      checkValue("fetch_grant_back", 64'(rrGrant), 64'd1);

      runRefresh(4, 2, -1, -1);
      checkValue("hit_rd_cycles", 64'(rrRd), 64'd0);
      checkValue("hit_valid_count", 64'(rrValid), 64'd1);
      checkValue("hit_valid_at", 64'(rrValidAt), 64'd1);
      checkValue("hit_dout", 64'(rrDout), 64'h3C);

      bus.tape_addr = 25'h0400020;
      rdData        = 8'hC3;
      runRefresh(3, 2, -1, -1);
      checkValue("abort_rd_cycles", 64'(rrRd), 64'd2);
      checkValue("abort_valid_count", 64'(rrValid), 64'd0);
      runRefresh(10, 2, -1, -1);
      checkValue("retry_valid_count", 64'(rrValid), 64'd1);
      checkValue("retry_dout", 64'(rrDout), 64'hC3);
      checkValue("retry_rd_cycles", 64'(rrRd), 64'd6);

      bus.tape_addr = 25'h0400030;
      rdData        = 8'h99;
      runRefresh(10, 2, 3, -1);
      checkValue("drop_valid_count", 64'(rrValid), 64'd1);
      checkValue("drop_dout", 64'(rrDout), 64'h99);
      bus.tape_rd = 1'b1;

      bus.tape_addr = 25'h0400040;
      rdData        = 8'h42;
      runRefresh(10, 4, -1, 3);
      checkValue("dl_abort_rd_cycles", 64'(rrRd), 64'd3);
      checkValue("dl_abort_valid_count", 64'(rrValid), 64'd0);
      runRefresh(10, 2, -1, -1);
      checkValue("dl_retry_valid_count", 64'(rrValid), 64'd1);
      checkValue("dl_retry_dout", 64'(rrDout), 64'h42);
`else
      runRefresh(10, 2, -1, -1);
      checkValue("notape_rd_cycles", 64'(rrRd), 64'd0);
      checkValue("notape_we_cycles", 64'(rrWe), 64'd0);
      checkValue("notape_valid_count", 64'(rrValid), 64'd0);
      checkValue("notape_dout", 64'(bus.tape_dout), 64'd0);
`endif

      nextCycle();
      nRESET     = 1'b0;
      bus.dl_req = 1'b1;
      @(negedge clk_sys);
      checkValue("rereset_grant", 64'(bus.grant), 64'd0);
      checkValue("rereset_tape_valid", 64'(bus.tape_valid), 64'd0);
      nextCycle();
      nRESET = 1'b1;
      @(negedge clk_sys);
      checkValue("rerelease_grant_idle", 64'(bus.grant), 64'd0);
      nextCycle();
      @(negedge clk_sys);
      checkValue("rerelease_grant_dl", 64'(bus.grant), 64'd2);
      nextCycle();
      bus.dl_req = 1'b0;
      repeat (3) nextCycle();
      @(negedge clk_sys);
      checkValue("final_grant_cpu", 64'(bus.grant), 64'd1);

      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
